// File: rtl/fifo_rd_stream_if.sv
// Stream-side bundle for fifo_rd_stream: RAM read port toward the FIFO plus the
// valid/ready output stream toward the consumer.
interface fifo_rd_stream_if #(
    parameter int Width = 4
);
    logic             i_rd_empty;
    logic             o_rd_en;
    logic [Width-1:0] i_rd_data;
    logic             o_valid;
    logic             i_ready;
    logic [Width-1:0] o_data;

    modport master (
        input  i_rd_empty,
        input  i_rd_data,
        input  i_ready,
        output o_rd_en,
        output o_valid,
        output o_data
    );

    modport slave (
        output i_rd_empty,
        output i_rd_data,
        output i_ready,
        input  o_rd_en,
        input  o_valid,
        input  o_data
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: issues RAM reads, absorbs the 1-cycle
// read latency and buffers into a head/skid pair. FIFO_RD_STREAM_STATS_EN adds o_beats.
module fifo_rd_stream #(
    parameter int Width    = 4,
    parameter int CntWidth = 16
) (
    input  logic                clk_rd,
    input  logic                rst,
    fifo_rd_stream_if.master    sif
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    output logic [CntWidth-1:0] o_beats
`endif
);

    logic             head_valid_r;
    logic [Width-1:0] head_data_r;
    logic             skid_valid_r;
    logic [Width-1:0] skid_data_r;
    logic             pending_r;

    logic             head_valid_s;
    logic [Width-1:0] head_data_s;
    logic             skid_valid_s;
    logic [Width-1:0] skid_data_s;
    logic             pop_s;
    logic [1:0]       count_s;
    logic [2:0]       occ_s;
    logic             rd_en_s;

    // Read issue: allow a request only if the data it returns will have a slot.
    always_comb begin
        pop_s   = head_valid_r & sif.i_ready;
        count_s = {1'b0, head_valid_r} + {1'b0, skid_valid_r};
        occ_s   = {1'b0, count_s} + {2'b00, pending_r} - {2'b00, pop_s};
        rd_en_s = ~rst & ~sif.i_rd_empty & (occ_s <= 3'd1);
    end

    // Placement of an arriving word and of the skid entry; FIFO order preserved.
    always_comb begin
        head_valid_s = head_valid_r;
        head_data_s  = head_data_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        if (pop_s) begin
            if (skid_valid_r) begin
                head_valid_s = 1'b1;
                head_data_s  = skid_data_r;
                if (pending_r) begin
                    skid_valid_s = 1'b1;
                    skid_data_s  = sif.i_rd_data;
                end else begin
                    skid_valid_s = 1'b0;
                end
            end else begin
                if (pending_r) begin
                    head_valid_s = 1'b1;
                    head_data_s  = sif.i_rd_data;
                end else begin
                    head_valid_s = 1'b0;
                end
            end
        end else if (pending_r) begin
            if (head_valid_r) begin
                skid_valid_s = 1'b1;
                skid_data_s  = sif.i_rd_data;
            end else begin
                head_valid_s = 1'b1;
                head_data_s  = sif.i_rd_data;
            end
        end else begin
            head_valid_s = head_valid_r;
        end
    end

    // Head, skid and in-flight registers; reset drops everything buffered.
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            head_valid_r <= 1'b0;
            head_data_r  <= {Width{1'b0}};
            skid_valid_r <= 1'b0;
            skid_data_r  <= {Width{1'b0}};
            pending_r    <= 1'b0;
        end else begin
            head_valid_r <= head_valid_s;
            head_data_r  <= head_data_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            pending_r    <= rd_en_s;
        end
    end

    assign sif.o_rd_en = rd_en_s;
    assign sif.o_valid = head_valid_r;
    assign sif.o_data  = head_data_r;

`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CntWidth-1:0] beats_r;

    // Accepted-beat counter, saturating at all-ones.
    always_ff @(posedge clk_rd) begin
        if (rst) begin
            beats_r <= {CntWidth{1'b0}};
        end else if (pop_s && !(&beats_r)) begin
            beats_r <= beats_r + {{(CntWidth-1){1'b0}}, 1'b1};
        end else begin
            beats_r <= beats_r;
        end
    end

    assign o_beats = beats_r;
`else
    logic [CntWidth-1:0] unused_cnt_s;
    assign unused_cnt_s = {CntWidth{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a FIFO/RAM model feeds the block, expected
// words are queued when loaded and a monitor checks every accepted beat.
module tb_fifo_rd_stream;

    localparam int CW = 4;

    logic clk_rd;
    logic rst;
    fifo_rd_stream_if #(.Width(4)) rif ();
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [CW-1:0] beats;
`endif

    fifo_rd_stream #(.Width(4), .CntWidth(CW)) dut (
        .clk_rd (clk_rd),
        .rst    (rst),
        .sif    (rif)
`ifdef FIFO_RD_STREAM_STATS_EN
        ,
        .o_beats(beats)
`endif
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int rd_pulses = 0;
    int rd_base;
    logic [3:0] mem_q[$];
    logic [3:0] exp_q[$];
    logic issue;
    logic prev_stall;
    logic [3:0] prev_data;
    logic [3:0] w;
    logic rd_h[12];
    logic v_h[12];
    logic [3:0] d_h[12];

    initial begin
        clk_rd = 1'b0;
        forever #5 clk_rd = ~clk_rd;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_rd);
        #1;
    endtask

    task automatic push(input logic [3:0] v);
        mem_q.push_back(v);
        exp_q.push_back(v);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    // FIFO/RAM model: a read issued in one cycle returns its word in the next.
    initial begin
        rif.i_rd_empty = 1'b1;
        rif.i_rd_data  = 4'h0;
        issue = 1'b0;
        forever begin
            @(negedge clk_rd);
            if (issue && mem_q.size() > 0) rif.i_rd_data = mem_q.pop_front();
            #2;
            rif.i_rd_empty = (mem_q.size() == 0);
            #1;
            issue = rif.o_rd_en;
        end
    end

    // Monitor: compares every accepted beat against the scoreboard.
    initial begin
        prev_stall = 1'b0;
        prev_data  = 4'h0;
        forever begin
            @(negedge clk_rd);
            #3;
            if (rst) chk("rd_en_in_reset", 32'(rif.o_rd_en), 32'd0);
            if (rif.o_rd_en === 1'b1) begin
                rd_pulses++;
                chk("rd_en_while_empty", 32'(rif.i_rd_empty), 32'd0);
            end
            if (prev_stall) begin
                chk("hold_valid", 32'(rif.o_valid), 32'd1);
                chk("hold_data", 32'(rif.o_data), 32'(prev_data));
            end
            if (rif.o_valid === 1'b1 && rif.i_ready === 1'b1 && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(rif.o_data), 32'hFFFF_FFFF);
                end else begin
                    chk("beat_data", 32'(rif.o_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = rif.o_valid && !rif.i_ready && !rst;
            prev_data  = rif.o_data;
        end
    end

    task automatic mid_reset(input int at, input logic [3:0] base);
        tick();
        rif.i_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(base + 4'(i));
        for (int c = 1; c < at; c++) tick();
        tick();
        rst = 1'b1;
        mem_q.delete();
        exp_q.delete();
        tick();
        rst = 1'b0;
        #3;
        chk("mid_rst_valid0", 32'(rif.o_valid), 32'd0);
        tick();
        #3;
        chk("mid_rst_valid1", 32'(rif.o_valid), 32'd0);
        chk("mid_rst_rd_en", 32'(rif.o_rd_en), 32'd0);
        tick();
        rif.i_ready = 1'b1;
        push(4'h3);
        drain(10);
    endtask

    // Directed stimulus.
    initial begin
        rst = 1'b1;
        rif.i_ready = 1'b0;
        push(4'h5);
        for (int c = 0; c < 3; c++) begin
            tick();
            #3;
            chk("rst_rd_en", 32'(rif.o_rd_en), 32'd0);
            chk("rst_valid", 32'(rif.o_valid), 32'd0);
            chk("rst_data", 32'(rif.o_data), 32'd0);
        end
        rd_base = rd_pulses;
        tick();
        rst = 1'b0;
        #3;
        chk("first_rd_en", 32'(rif.o_rd_en), 32'd1);
        tick();
        #3;
        chk("n1_valid", 32'(rif.o_valid), 32'd0);
        chk("n1_rd_en", 32'(rif.o_rd_en), 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            #3;
            chk("single_valid", 32'(rif.o_valid), 32'd1);
            chk("single_data", 32'(rif.o_data), 32'h5);
        end
        chk("single_pulses", 32'(rd_pulses - rd_base), 32'd1);
        tick();
        rif.i_ready = 1'b1;
        tick();
        #3;
        chk("after_pop_valid", 32'(rif.o_valid), 32'd0);

        // Streaming 0..7 with the consumer always ready.
        tick();
        for (int i = 0; i < 8; i++) push(4'(i));
        #3;
        rd_h[0] = rif.o_rd_en; v_h[0] = rif.o_valid; d_h[0] = rif.o_data;
        for (int c = 1; c < 12; c++) begin
            tick();
            #3;
            rd_h[c] = rif.o_rd_en; v_h[c] = rif.o_valid; d_h[c] = rif.o_data;
        end
        for (int c = 0; c < 8; c++) chk("stream_rd_en", 32'(rd_h[c]), 32'd1);
        chk("stream_rd_en_end", 32'(rd_h[8]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(v_h[i + 2]), 32'd1);
            chk("stream_data", 32'(d_h[i + 2]), 32'(i));
        end
        drain(10);

        // Backpressure: stall for 4 cycles mid-stream.
        tick();
        for (int i = 0; i < 10; i++) begin
            w = 4'(i + 8);
            push(w);
        end
        for (int c = 1; c < 4; c++) tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            rif.i_ready = 1'b0;
            #3;
            chk("stall_rd_en", 32'(rif.o_rd_en), 32'd0);
        end
        tick();
        rif.i_ready = 1'b1;
        drain(40);

        // Reset with a read in flight, then with both registers full.
        mid_reset(2, 4'h1);
        mid_reset(3, 4'h9);

`ifdef FIFO_RD_STREAM_STATS_EN
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        chk("beats_reset", 32'(beats), 32'd0);
        for (int i = 0; i < 20; i++) push(4'(i));
        drain(60);
        tick();
        #3;
        chk("beats_sat", 32'(beats), 32'd15);
        for (int c = 0; c < 3; c++) tick();
        #3;
        chk("beats_hold", 32'(beats), 32'd15);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #3;
        chk("beats_clear", 32'(beats), 32'd0);
`endif

        for (int c = 0; c < 3; c++) tick();
        chk("final_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
